// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps every detection pulse from the upstream
// 101 sequence detector and queues the timestamps in a small
// first-word-fall-through FIFO. It also keeps a saturating event count and a
// sticky overflow flag.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   det_in     : detection pulse; one event per edge at which it is high
//   clear      : synchronous clear of all logger state (beats det_in/rd_en)
//   rd_en      : pop the FIFO head when rd_valid is high
//   rd_data    : timestamp at the FIFO head (valid only while rd_valid)
//   rd_valid   : FIFO non-empty
//   fifo_level : number of entries held, 0..DEPTH
//   count      : detections since reset/clear, saturating
//   overflow   : sticky, a detection was dropped because the FIFO was full
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally modulo DEPTH.
module detect_event_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     det_in,
  input  logic                     clear,
  input  logic                     rd_en,
  output logic [TS_W-1:0]          rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [TS_W-1:0]  ts_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [TS_W-1:0]  mem [DEPTH];

  logic pop_c;
  logic full_c;
  logic wr_c;
  logic drop_c;
  logic cnt_sat_c;

  // Handshake decode; clear masks both det_in and rd_en for its cycle.
  always_comb begin
    pop_c     = rd_en && (fifo_level != '0) && !clear;
    full_c    = (fifo_level == LVL_W'(DEPTH));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_c      = det_in && !clear && (!full_c || pop_c);
    drop_c    = det_in && !clear && full_c && !pop_c;
    cnt_sat_c = (count == '1);
  end

  // Timestamp, pointers, level, count and overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (wr_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // Level is tracked separately so full and empty are unambiguous.
      if (wr_c && !pop_c) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (pop_c && !wr_c) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
      // Every event counts, accepted or dropped.
      if (det_in && !cnt_sat_c) begin
        count <= count + CNT_W'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; entries are only visible through rd_valid.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_ptr_q] <= ts_q;
    end
  end

  // Head read straight from registered storage gives fall-through behaviour.
  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = (fifo_level != '0);

endmodule

// File: tb/tb_detect_event_logger.sv
// Self-checking bench for detect_event_logger (TS_W=4 to reach the timestamp
// wrap quickly, CNT_W=8, DEPTH=4). A reference model pushes expected
// timestamps into a scoreboard queue as events are driven; the head is
// compared against rd_data whenever the DUT presents it.
module tb_detect_event_logger;

  localparam int unsigned TS_W   = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TS_MOD = 1 << TS_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   det_in;
  logic                   clear;
  logic                   rd_en;
  logic [TS_W-1:0]        rd_data;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]       count;
  logic                   overflow;

  detect_event_logger #(
    .TS_W (TS_W),
    .CNT_W(CNT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .det_in    (det_in),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .fifo_level(fifo_level),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  int unsigned sb[$];
  int unsigned m_ts  = 0;
  int unsigned m_cnt = 0;
  int unsigned m_ovf = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    sb.delete();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance
  // the model and the DUT by one rising edge. Entered and left at posedge+1.
  task automatic cycle(input logic det, input logic rd, input logic clr);
    bit          pop;
    bit          full;
    int unsigned tmp;
    det_in = det;
    rd_en  = rd;
    clear  = clr;
    #1;
    check("rd_valid", rd_valid, (sb.size() != 0) ? 1 : 0);
    check("fifo_level", fifo_level, sb.size());
    check("count", count, m_cnt);
    check("overflow", overflow, m_ovf);
    if (sb.size() != 0) check("rd_data", rd_data, sb[0]);
    if (clr) begin
      model_reset();
    end else begin
      pop  = rd && (sb.size() != 0);
      full = (sb.size() == DEPTH);
      if (pop) tmp = sb.pop_front();
      if (det) begin
        if (!full || pop) sb.push_back(m_ts);
        else m_ovf = 1;
        if (m_cnt != CNT_MAX) m_cnt++;
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
    @(posedge clk);
    #1;
  endtask

  // Directed head check followed by a pop.
  task automatic pop_expect(input string tag, input int unsigned exp);
    check(tag, rd_data, exp);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    det_in = 1'b0;
    clear  = 1'b0;
    rd_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", fifo_level, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    model_reset();

    // Single event on the third edge carries timestamp 2
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("single_valid", rd_valid, 1);
    check("single_data", rd_data, 2);
    check("single_count", count, 1);
    check("single_level", fifo_level, 1);
    cycle(1'b0, 1'b1, 1'b0);
    check("single_pop_valid", rd_valid, 0);
    check("single_pop_level", fifo_level, 0);

    // Read on an empty FIFO is ignored
    cycle(1'b0, 1'b1, 1'b0);
    check("empty_rd_level", fifo_level, 0);

    // Fill past capacity
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
    check("fill_level", fifo_level, 4);
    check("fill_count", count, 6);
    check("fill_ovf", overflow, 1);
    pop_expect("fill_pop0", 0);
    pop_expect("fill_pop1", 1);
    pop_expect("fill_pop2", 2);
    pop_expect("fill_pop3", 3);
    check("fill_empty", rd_valid, 0);

    // Simultaneous pop and push while full
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("pp_level", fifo_level, 4);
    check("pp_ovf", overflow, 0);
    pop_expect("pp_pop0", 1);
    pop_expect("pp_pop1", 2);
    pop_expect("pp_pop2", 3);
    pop_expect("pp_pop3", 10);

    // Timestamp wrap: events at ts=15 and then ts=0
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    pop_expect("wrap_pop0", 15);
    pop_expect("wrap_pop1", 0);

    // Count saturation with mixed reads
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0);
    check("sat_count", count, 255);
    cycle(1'b1, 1'b0, 1'b0);
    check("sat_hold", count, 255);

    // Clear beats det_in and rd_en on a non-empty FIFO
    cycle(1'b1, 1'b1, 1'b1);
    check("clr_count", count, 0);
    check("clr_level", fifo_level, 0);
    check("clr_ovf", overflow, 0);

    // Random traffic
    for (int i = 0; i < 200; i++)
      cycle(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 40) == 0));

    // Asynchronous reset mid-fill
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_level", fifo_level, 0);
    check("arst_count", count, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_ovf", overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0);
    check("post_rst_data", rd_data, 0);
    check("post_rst_count", count, 1);
    cycle(1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
